tx_word_arbiter: RTL and testbench

- Shares the single 32-bit word serializer and its UART transmitter among N_REQ word sources, e.g. the encrypter result, the decrypter result and status/key echo.
- Arbitrates round-robin and latches the winning word.
- Issues a one-cycle word_ready pulse to the serializer, then holds ownership until the serializer reports the whole word sent.
- A start watchdog flags a serializer that never accepts the word.

---
 rtl/tx_word_arbiter_pkg.sv | 12 +
 rtl/tx_word_arbiter_rr_picker.sv | 23 ++
 rtl/tx_word_arbiter.sv | 101 ++++++++++
 tb/tb_tx_word_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_word_arbiter_pkg.sv
// tx_word_arbiter_pkg: shared FSM encoding, default word width and round-robin wrap helper
package tx_word_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_END   = 2'd2
  } state_e;
  localparam int WORD_W_DEF = 32;
  function automatic int rr_wrap(input int a, input int n);
    return (a >= n) ? a - n : a;
  endfunction
endpackage

// File: rtl/tx_word_arbiter_rr_picker.sv
// tx_word_arbiter_rr_picker: combinational round-robin pick; req_i/last_grant_i in, sel_o index and valid_o out
module tx_word_arbiter_rr_picker
  import tx_word_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_grant_i,
  output logic [$clog2(N)-1:0] sel_o,
  output logic                 valid_o
);
  localparam int IW = $clog2(N);
  // scan farthest-first so the nearest requester after last_grant_i overwrites the rest
  always_comb begin
    sel_o   = '0;
    valid_o = 1'b0;
    for (int k = N; k >= 1; k--)
      if (req_i[IW'(rr_wrap(int'(last_grant_i) + k, N))]) begin
        sel_o   = IW'(rr_wrap(int'(last_grant_i) + k, N));
        valid_o = 1'b1;
      end
  end
endmodule

// File: rtl/tx_word_arbiter.sv
// tx_word_arbiter: round-robin share of one word serializer; req/req_data in, ack/word_ready/word_out/busy/grant_id/err_timeout out
module tx_word_arbiter
  import tx_word_arbiter_pkg::*;
#(
  parameter int N_REQ         = 3,
  parameter int WORD_W        = WORD_W_DEF,
  parameter int START_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic                      word_ready,
  output logic [WORD_W-1:0]         word_out,
  input  logic                      sending_word,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      err_timeout
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  state_e             state_q, state_d;
  logic [IW-1:0]      last_q, last_d, grant_q, grant_d, sel;
  logic               sel_vld;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               wr_q, wr_d, err_q, err_d;
  logic [WORD_W-1:0]  word_q, word_d;

  tx_word_arbiter_rr_picker #(.N(N_REQ)) u_pick (
    .req_i       (req),
    .last_grant_i(last_q),
    .sel_o       (sel),
    .valid_o     (sel_vld)
  );

  // the pointer only advances once the granted word is finished or dropped
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    wr_d    = 1'b0;
    word_d  = word_q;
    err_d   = err_q;
    case (state_q)
      IDLE:
        if (sel_vld) begin
          state_d = WAIT_START;
          grant_d = sel;
          ack_d   = N_REQ'(1) << sel;
          wr_d    = 1'b1;
          word_d  = req_data[int'(sel)*WORD_W +: WORD_W];
          cnt_d   = '0;
        end
      WAIT_START:
        if (sending_word) state_d = WAIT_END;
        else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end else cnt_d = cnt_q + CW'(1);
      WAIT_END:
        if (!sending_word) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(N_REQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end

  assign ack         = ack_q;
  assign word_ready  = wr_q;
  assign word_out    = word_q;
  assign busy        = state_q != IDLE;
  assign grant_id    = grant_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_tx_word_arbiter.sv
// tb_tx_word_arbiter: table rows plus corner sequences, grants checked against a queue of expected words
module tb_tx_word_arbiter;
  localparam int N = 3, W = 32, TO = 16;
  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic           sending_word = 1'b0;
  logic [N-1:0]   ack;
  logic           word_ready, busy, err_timeout;
  logic [W-1:0]   word_out;
  logic [1:0]     grant_id;

  typedef struct packed {logic [1:0] id; logic [31:0] word;} exp_t;
  typedef struct packed {logic [2:0] req; int n; logic [5:0] ord;} vec_t;
  exp_t   q[$];
  exp_t   e_mon;
  vec_t   tbl[6];
  int     tests = 0, fails = 0, cyc = 0, wr_cyc = 0, ser_hold = 4, keep = 0, ack0_cnt = 0, t0 = 0;
  bit     ser_en = 1'b1, no_drop = 1'b0;
  logic   prev_wr = 1'b0;
  logic [N-1:0] a_hold;

  tx_word_arbiter #(.N_REQ(N), .WORD_W(W), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .word_ready(word_ready), .word_out(word_out), .sending_word(sending_word),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic sig(input int w);
    return w == 0 ? word_ready : w == 1 ? sending_word : err_timeout;
  endfunction

  task automatic wait_for(input int w, input logic lvl, input string name);
    int n = 0;
    while (sig(w) !== lvl && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s: signal %0d stuck, wanted %b", name, w, lvl);
    end
  endtask

  task automatic push(input logic [1:0] id);
    exp_t x;
    x.id   = id;
    x.word = req_data[int'(id)*W +: W];
    q.push_back(x);
  endtask

  task automatic set_words(input int r);
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'(32'h11111111 * (i + 1) + (r << 24));
  endtask

  task automatic do_reset(input logic [N-1:0] mask_after);
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    q.delete();
    rst = 1'b0;
    req = mask_after;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 600 && (q.size() != 0 || busy || req != 0); i++) tick();
    chk({name, "_drained"}, 32'({q.size() != 0, busy, req != 0}), 0);
  endtask

  // grant monitor / scoreboard consumer
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) prev_wr = 1'b0;
    else begin
      if (word_ready) begin
        chk("wr_back_to_back", 32'(prev_wr), 0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: got id %0d word %h, expected no grant", grant_id, word_out);
        end else begin
          e_mon = q.pop_front();
          chk("grant_id", 32'(grant_id), 32'(e_mon.id));
          chk("word_out", word_out, e_mon.word);
          chk("ack_onehot", 32'(ack), 32'(1) << e_mon.id);
        end
        wr_cyc = cyc;
        if (ack[0]) ack0_cnt++;
      end else chk("ack_without_wr", 32'(ack), 0);
      prev_wr = word_ready;
    end
  end

  // requesters drop req keep cycles after their ack
  initial forever begin
    @(posedge clk);
    #1;
    if (|ack && !no_drop) begin
      a_hold = ack;
      repeat (keep) @(posedge clk);
      if (keep > 0) #1;
      req = req & ~a_hold;
    end
  end

  // serializer: raises sending_word the cycle after word_ready, holds ser_hold cycles
  initial forever begin
    @(posedge clk);
    #1;
    if (word_ready && ser_en && !rst) begin
      @(posedge clk);
      #1 sending_word = 1'b1;
      repeat (ser_hold) @(posedge clk);
      #1 sending_word = 1'b0;
    end
  end

  initial begin
    #300000;
    fails++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    tbl[0] = '{3'b111, 3, 6'b10_01_00};
    tbl[1] = '{3'b110, 2, 6'b00_10_01};
    tbl[2] = '{3'b101, 2, 6'b00_10_00};
    tbl[3] = '{3'b100, 1, 6'b00_00_10};
    tbl[4] = '{3'b011, 2, 6'b00_01_00};
    tbl[5] = '{3'b010, 1, 6'b00_00_01};
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_word_ready", 32'(word_ready), 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_err", 32'(err_timeout), 0);
    for (int r = 0; r < 6; r++) begin
      set_words(r);
      do_reset(tbl[r].req);
      for (int k = 0; k < tbl[r].n; k++) push(tbl[r].ord[2*k +: 2]);
      wait_done($sformatf("row%0d", r));
    end
    do_reset('0);
    req_data[31:0] = 32'hDEADBEEF;
    ser_hold = 40;
    tick();
    t0 = cyc;
    push(2'd0);
    req = 3'b001;
    wait_for(0, 1'b1, "t1_wr");
    chk("t1_ack_latency", 32'(cyc - t0), 1);
    chk("t1_busy", 32'(busy), 1);
    wait_for(1, 1'b1, "t1_send_rise");
    wait_for(1, 1'b0, "t1_send_fall");
    chk("t1_busy_at_fall", 32'(busy), 1);
    tick();
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_word_hold", word_out, 32'hDEADBEEF);
    ser_hold = 4;
    do_reset('0);
    set_words(0);
    no_drop = 1'b1;
    push(2'd0); push(2'd1); push(2'd2); push(2'd0);
    req = 3'b111;
    for (int i = 0; i < 300 && q.size() != 0; i++) tick();
    req = '0;
    no_drop = 1'b0;
    wait_done("t2");
    do_reset('0);
    set_words(7);
    ser_en = 1'b0;
    push(2'd0); push(2'd1);
    req = 3'b011;
    wait_for(0, 1'b1, "t4_wr");
    t0 = cyc;
    wait_for(2, 1'b1, "t4_err");
    chk("t4_timeout_cycles", 32'(cyc - t0), TO);
    chk("t4_idle", 32'(busy), 0);
    ser_en = 1'b1;
    wait_done("t4");
    chk("t4_err_sticky", 32'(err_timeout), 1);
    set_words(9);
    push(2'd0);
    req = 3'b001;
    wait_for(0, 1'b1, "t5_wr");
    wait_for(1, 1'b1, "t5_send");
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ack", 32'(ack), 0);
    chk("t5_wr", 32'(word_ready), 0);
    chk("t5_word_out", word_out, 0);
    chk("t5_err", 32'(err_timeout), 0);
    q.delete();
    wait_for(1, 1'b0, "t5_ser_idle");
    rst = 1'b0;
    req = 3'b111;
    push(2'd0); push(2'd1); push(2'd2);
    wait_done("t5");
    do_reset('0);
    set_words(11);
    keep = 2;
    ack0_cnt = 0;
    push(2'd0);
    req = 3'b001;
    wait_done("t6");
    chk("t6_single_ack", 32'(ack0_cnt), 1);
    keep = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
